// File: rtl/am2910.sv
// 12-bit microprogram sequencer: picks the next microcode address from the microPC,
// the R register/counter, a small return/loop stack or the direct input d.
module am2910 #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5
) (
  input  logic             cp,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       i,
  input  logic             cc_,
  input  logic             ccen_,
  input  logic             ci,
  input  logic             rld_,
  input  logic             oe_,
  output logic [WIDTH-1:0] y,
  output logic             pl_,
  output logic             map_,
  output logic             vect_,
  output logic             full_
);
  localparam int SPW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    JZ = 4'd0, CJS = 4'd1, JMAP = 4'd2, CJP = 4'd3, PUSH = 4'd4, JSRP = 4'd5,
    CJV = 4'd6, JRP = 4'd7, RFCT = 4'd8, RPCT = 4'd9, CRTN = 4'd10, CJPP = 4'd11,
    LDCT = 4'd12, LOOP = 4'd13, CONT = 4'd14, TWB = 4'd15
  } instr_e;

  logic [WIDTH-1:0] upc_q, upc_d, r_q, r_d;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d, top_idx, wr_idx;
  logic             full_q, full_d;

  logic [WIDTH-1:0] y_int, f_val;
  logic             pass, rnz, push, pop, clr, ld, dec;
  instr_e           op;

  assign op      = instr_e'(i);
  assign pass    = ccen_ | ~cc_;
  assign rnz     = (r_q != '0);
  // An empty stack still presents entry 0 as F.
  assign top_idx = (sp_q == '0) ? '0 : sp_q - SPW'(1);
  assign f_val   = stk_q[top_idx];
  assign wr_idx  = (sp_q == SPW'(DEPTH)) ? SPW'(DEPTH - 1) : sp_q;

  always_comb begin
    y_int = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    ld    = 1'b0;
    dec   = 1'b0;
    pl_   = 1'b0;
    map_  = 1'b1;
    vect_ = 1'b1;
    unique case (op)
      JZ:   begin y_int = '0; clr = 1'b1; end
      CJS:  if (pass) begin y_int = d; push = 1'b1; end
      JMAP: begin y_int = d; pl_ = 1'b1; map_ = 1'b0; end
      CJP:  if (pass) y_int = d;
      PUSH: begin push = 1'b1; ld = pass; end
      JSRP: begin y_int = pass ? d : r_q; push = 1'b1; end
      CJV:  begin if (pass) y_int = d; pl_ = 1'b1; vect_ = 1'b0; end
      JRP:  y_int = pass ? d : r_q;
      RFCT: if (rnz) begin y_int = f_val; dec = 1'b1; end
            else pop = 1'b1;
      RPCT: if (rnz) begin y_int = d; dec = 1'b1; end
      CRTN: if (pass) begin y_int = f_val; pop = 1'b1; end
      CJPP: if (pass) begin y_int = d; pop = 1'b1; end
      LDCT: ld = 1'b1;
      LOOP: if (pass) pop = 1'b1;
            else y_int = f_val;
      CONT: ;
      TWB:  if (pass) pop = 1'b1;
            else if (rnz) begin y_int = f_val; dec = 1'b1; end
            else begin y_int = d; pop = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    upc_d = y_int + WIDTH'(ci);
    r_d   = r_q;
    if (!rld_ || ld) r_d = d;
    else if (dec)    r_d = r_q - WIDTH'(1);
    sp_d = sp_q;
    if (clr)                    sp_d = '0;
    else if (push)              sp_d = (sp_q == SPW'(DEPTH)) ? sp_q : sp_q + SPW'(1);
    else if (pop && sp_q != '0) sp_d = sp_q - SPW'(1);
    full_d = ~(sp_d == SPW'(DEPTH));
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      upc_q  <= '0;
      r_q    <= '0;
      sp_q   <= '0;
      full_q <= 1'b1;
    end else begin
      upc_q  <= upc_d;
      r_q    <= r_d;
      sp_q   <= sp_d;
      full_q <= full_d;
    end
  end

  // Stack contents survive reset; only the pointer is cleared.
  always_ff @(posedge cp) begin
    if (!rst && push) stk_q[wr_idx] <= upc_q;
  end

  assign y     = oe_ ? {WIDTH{1'bz}} : y_int;
  assign full_ = full_q;

endmodule

// File: tb/tb_am2910.sv
// Randomized + directed bench for am2910; a queue-based stack model predicts outputs,
// a negedge monitor pops and compares them.
module tb_am2910;
  localparam int W = 12;
  localparam int DEPTH = 5;

  logic         cp = 1'b0, rst = 1'b1;
  logic [W-1:0] d = '0;
  logic [3:0]   i = 4'd14;
  logic         cc_ = 1'b1, ccen_ = 1'b1, ci = 1'b0, rld_ = 1'b1, oe_ = 1'b0;
  logic [W-1:0] y;
  logic         pl_, map_, vect_, full_;

  am2910 #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .cp(cp), .rst(rst), .d(d), .i(i), .cc_(cc_), .ccen_(ccen_), .ci(ci),
    .rld_(rld_), .oe_(oe_), .y(y), .pl_(pl_), .map_(map_), .vect_(vect_), .full_(full_)
  );

  always #5 cp = ~cp;

  typedef struct {
    string        name;
    bit           ychk;
    logic [W-1:0] y;
    logic [2:0]   src;   // {pl_, map_, vect_}
    logic         full;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  // reference model state
  int           m_upc = 0, m_r = 0;
  logic [W-1:0] m_stk[$];
  logic [W-1:0] m_bot = '0;

  task automatic model_reset();
    m_upc = 0;
    m_r = 0;
    m_stk.delete();
  endtask

  task automatic step(input string name, input int ii, input int dd, input bit cc,
                      input bit ccen, input bit cin, input bit rld, input bit oe);
    exp_t e;
    bit pass, rnz, psh, pp, clr, ld, dec;
    int ny, f;
    @(posedge cp); #1;
    rst = 1'b0; i = 4'(ii); d = W'(dd); cc_ = cc; ccen_ = ccen; ci = cin; rld_ = rld; oe_ = oe;
    pass = ccen || !cc;
    rnz = (m_r != 0);
    f = (m_stk.size() > 0) ? int'(m_stk[m_stk.size()-1]) : int'(m_bot);
    ny = m_upc; psh = 0; pp = 0; clr = 0; ld = 0; dec = 0;
    case (ii)
      0:  begin ny = 0; clr = 1; end
      1:  if (pass) begin ny = dd; psh = 1; end
      2:  ny = dd;
      3:  if (pass) ny = dd;
      4:  begin psh = 1; ld = pass; end
      5:  begin ny = pass ? dd : m_r; psh = 1; end
      6:  if (pass) ny = dd;
      7:  ny = pass ? dd : m_r;
      8:  if (rnz) begin ny = f; dec = 1; end else pp = 1;
      9:  if (rnz) begin ny = dd; dec = 1; end
      10: if (pass) begin ny = f; pp = 1; end
      11: if (pass) begin ny = dd; pp = 1; end
      12: ld = 1;
      13: if (pass) pp = 1; else ny = f;
      14: ;
      default: if (pass) pp = 1;
               else if (rnz) begin ny = f; dec = 1; end
               else begin ny = dd; pp = 1; end
    endcase
    e.name = name;
    e.ychk = !oe;
    e.y    = W'(ny);
    e.src  = (ii == 2) ? 3'b101 : (ii == 6) ? 3'b110 : 3'b011;
    e.full = (m_stk.size() != DEPTH);
    sb.push_back(e);
    // state after the coming edge
    if (clr) m_stk.delete();
    else if (psh) begin
      if (m_stk.size() == DEPTH) m_stk[DEPTH-1] = W'(m_upc);
      else begin
        if (m_stk.size() == 0) m_bot = W'(m_upc);
        m_stk.push_back(W'(m_upc));
      end
    end else if (pp && m_stk.size() > 0) void'(m_stk.pop_back());
    if (!rld || ld) m_r = dd;
    else if (dec)   m_r = m_r - 1;
    m_upc = (ny + int'(cin)) % (1 << W);
  endtask

  // Reset lands mid-cycle; outputs must reflect it before any clock edge.
  task automatic async_reset(input string name);
    exp_t e;
    @(posedge cp); #1;
    rst = 1'b1; i = 4'd14; oe_ = 1'b0;
    model_reset();
    e.name = name; e.ychk = 1; e.y = '0; e.src = 3'b011; e.full = 1'b1;
    sb.push_back(e);
  endtask

  always @(negedge cp) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.ychk) begin
        n_chk++;
        if (y !== e.y) begin
          n_fail++;
          $display("FAIL %s y: got %h expected %h", e.name, y, e.y);
        end
      end
      n_chk++;
      if ({pl_, map_, vect_} !== e.src) begin
        n_fail++;
        $display("FAIL %s src enables: got %b expected %b", e.name, {pl_, map_, vect_}, e.src);
      end
      n_chk++;
      if (full_ !== e.full) begin
        n_fail++;
        $display("FAIL %s full_: got %b expected %b", e.name, full_, e.full);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge cp);
    // reset state and counting
    repeat (5) step("cont", 14, 0, 1, 0, 1, 1, 0);
    // subroutine call and return
    step("cjs", 1, 'h100, 0, 0, 1, 1, 0);
    step("crtn", 10, 0, 0, 0, 1, 1, 0);
    // counted repeat
    step("ldct2", 12, 2, 1, 0, 1, 1, 0);
    repeat (3) step("rpct", 9, 'h040, 1, 0, 1, 1, 0);
    // stack overflow
    for (int k = 0; k < 6; k++) step("push", 4, 0, 1, 1, 1, 1, 0);
    step("crtn_full", 10, 0, 1, 1, 1, 1, 0);
    // TWB corners
    step("ldct0", 12, 0, 1, 0, 1, 1, 0);
    step("twb_r0", 15, 'h3FF, 1, 0, 1, 1, 0);
    step("ldct3", 12, 3, 1, 0, 1, 1, 0);
    step("twb_r3", 15, 'h123, 1, 0, 1, 1, 0);
    step("jrp_r", 7, 'h555, 1, 0, 1, 1, 0);
    // rld_ overrides decrement
    step("ldct4", 12, 4, 1, 0, 1, 1, 0);
    step("rfct_rld", 8, 9, 1, 0, 1, 0, 0);
    step("jrp_r9", 7, 'h555, 1, 0, 1, 1, 0);
    // microPC advances with output disabled
    step("oe_off", 3, 'h2AA, 0, 0, 1, 1, 1);
    step("after_oe", 14, 0, 1, 0, 1, 1, 0);
    // random traffic
    for (int k = 0; k < 400; k++)
      step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
           1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) != 0), 1'b0);
    // reset in the middle of a loop
    step("ldct_l", 12, 3, 1, 0, 1, 1, 0);
    step("push_l", 4, 0, 1, 0, 1, 1, 0);
    step("rfct_l", 8, 0, 1, 0, 1, 1, 0);
    async_reset("rst_mid");
    step("post_rst", 14, 0, 1, 0, 1, 1, 0);
    step("post_rst_jrp", 7, 0, 1, 0, 1, 1, 0);
    repeat (2) @(negedge cp);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/am2910.md
# am2910

12-bit microprogram sequencer that generates the next microinstruction address each cycle from the microPC, an internal register/counter, a 5-deep subroutine/loop stack or the direct input. It sits directly downstream of the status and shift control unit: that unit's `ct` output drives this block's `cc_` input, which closes the conditional branch loop. `y` addresses the microcode store. The `pl_`, `map_` and `vect_` outputs select which source drives `d`.

## Interface
- `WIDTH`, default 12: address, register/counter and stack entry width.
- `DEPTH`, default 5: number of stack entries.
- `cp`  in  1: clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `d`  in  WIDTH: direct input (pipeline, map PROM or vector source).
- `i`  in  4: instruction, 0–15.
- `cc_`  in  1: condition code, active-low. Connects to the status unit's `ct`.
- `ccen_`  in  1: condition enable, active-low. When high, the condition always passes.
- `ci`  in  1: microPC incrementer carry-in.
- `rld_`  in  1: register load, active-low. Loads `d` into R unconditionally.
- `oe_`  in  1: `y` output enable, active-low. When high, `y` is Z.
- `y`  out  WIDTH: next address, combinational.
- `pl_`, `map_`, `vect_`  out  1 each: source enables, active-low, combinational from `i`. Exactly one is low at any time.
- `full_`  out  1: low when the stack holds DEPTH entries.

## Operation
- State: `upc` (WIDTH bits), `r` (WIDTH bits), `stk[0..DEPTH-1]`, `sp` (0..DEPTH). F denotes the top of stack, `stk[sp-1]`.
- pass = `ccen_` | ~`cc_`. fail = ~pass. "R≠0" is evaluated on the pre-edge value of `r`.
- Instruction decode. Each entry gives `y` and the edge action; "push" pushes `upc`:
  - 0 JZ: `y`=0; `sp`←0.
  - 1 CJS: pass: `y`=d, push. Fail: `y`=upc.
  - 2 JMAP: `y`=d; `map_`=0.
  - 3 CJP: pass: `y`=d. Fail: `y`=upc.
  - 4 PUSH: `y`=upc; push; on pass, `r`←d.
  - 5 JSRP: pass: `y`=d. Fail: `y`=r. Push in both cases.
  - 6 CJV: pass: `y`=d. Fail: `y`=upc. `vect_`=0.
  - 7 JRP: pass: `y`=d. Fail: `y`=r.
  - 8 RFCT: R≠0: `y`=F, `r`−1. R=0: `y`=upc, pop.
  - 9 RPCT: R≠0: `y`=d, `r`−1. R=0: `y`=upc.
  - 10 CRTN: pass: `y`=F, pop. Fail: `y`=upc.
  - 11 CJPP: pass: `y`=d, pop. Fail: `y`=upc.
  - 12 LDCT: `y`=upc; `r`←d.
  - 13 LOOP: pass: `y`=upc, pop. Fail: `y`=F.
  - 14 CONT: `y`=upc.
  - 15 TWB: R≠0: fail: `y`=F, `r`−1; pass: `y`=upc, pop. R=0: fail: `y`=d, pop; pass: `y`=upc, pop.
- `pl_`=0 for every instruction except 2 and 6.
- Every edge: `upc` ← `y`(internal, pre-tristate) + `ci`, modulo 2^WIDTH. This applies even when `oe_`=1.
- When `rld_`=0, `r`←d. This overrides both the decrement and the conditional load.
- Stack rules:
  - Push writes `stk[sp]` and increments `sp`.
  - Push when full overwrites `stk[DEPTH-1]`; `sp` stays at DEPTH.
  - Pop when empty is a no-op.
  - F while empty reads `stk[0]`, whatever value it holds.
  - `full_` = ~(`sp`==DEPTH), registered from `sp`.
- The decrement wraps nowhere: it only occurs while R≠0.

## Timing
- `y`, `pl_`, `map_` and `vect_` are combinational from `i`, `cc_`, `ccen_`, `d` and state, with zero-cycle latency.
- All state updates on the rising edge of `cp`.
- `rst`=1 asynchronously sets `upc`=0, `r`=0, `sp`=0 and `full_`=1. Stack contents are not cleared.
- During reset, `y` still follows the decode; state holds until `rst` falls.
- Reset mid-subroutine discards the return addresses.
- `cc_` must settle within the same cycle. The status unit's `ct` is combinational and meets this.

## Test plan
- Reset, then CONT with `ci`=1 for 3 cycles → `y`=0,1,2; `full_`=1; `pl_`=0.
- CJS with `d`=12'h100, `cc_`=0, `ccen_`=0, upc=5 → `y`=100h, push 5. Then CRTN with pass → `y`=5, `sp`=0.
- LDCT `d`=2, then RPCT `d`=12'h040 for 3 cycles → `y`=040h, 040h, then upc; `r` goes 2,1,0.
- 6 consecutive PUSH instructions with `ccen_`=1 → `full_`=0 after the 5th; the 6th overwrites `stk[4]`; a following CRTN returns the 6th pushed upc.
- TWB with `r`=0, fail, `d`=12'h3FF → `y`=3FFh and pop. TWB with `r`=3, fail → `y`=F and `r`=2.
- `rld_`=0 during RFCT with `r`=4, `d`=9 → `r`=9 (not 3). Assert `rst` mid-loop → `sp`=0 and `upc`=0 immediately, without waiting for a clock edge.
